// File: rtl/iob_eth_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : iob_eth_axi_mem_responder
//  Purpose  : AXI4 slave frame memory behind the Ethernet DMA master. Accepts
//             write bursts (RX frames, BD write-back) and serves read bursts
//             (TX frames) from a word-addressed register array. One write and
//             one read burst may be outstanding at a time; the write and read
//             engines are independent.
//  Ports    : clk_i / arst_n_i      clock, asynchronous active-low reset
//             axi_aw* / axi_w* / axi_b*   AXI4 write address, data, response
//             axi_ar* / axi_r*            AXI4 read address and data
//             size/lock/cache/prot/qos inputs are accepted and ignored.
//  Revision : 1.0  initial release
// ============================================================================
module iob_eth_axi_mem_responder #(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  // write address channel
  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic [2:0]              axi_awsize_i,
  input  logic                    axi_awlock_i,
  input  logic [3:0]              axi_awcache_i,
  input  logic [2:0]              axi_awprot_i,
  input  logic [3:0]              axi_awqos_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  // write data channel
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  // write response channel
  output logic [AXI_ID_W-1:0]     axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  // read address channel
  input  logic [AXI_ID_W-1:0]     axi_arid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic [1:0]              axi_arburst_i,
  input  logic [2:0]              axi_arsize_i,
  input  logic                    axi_arlock_i,
  input  logic [3:0]              axi_arcache_i,
  input  logic [2:0]              axi_arprot_i,
  input  logic [3:0]              axi_arqos_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  // read data channel
  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i
);

  localparam int                    c_mem_depth   = 2 ** MEM_ADDR_W;
  localparam int                    c_lanes       = AXI_DATA_W / 8;
  localparam logic [1:0]            c_burst_fixed = 2'b00;
  localparam logic [1:0]            c_resp_okay   = 2'b00;
  localparam logic [1:0]            c_resp_slverr = 2'b10;
  localparam logic [1:0]            c_resp_decerr = 2'b11;
  localparam logic [MEM_ADDR_W-1:0] c_addr_one    = MEM_ADDR_W'(1);
  localparam logic [AXI_LEN_W-1:0]  c_cnt_one     = AXI_LEN_W'(1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LOAD = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  // --------------------------------------------------------------------------
  // Storage (not reset: contents survive a reset, including partial bursts)
  // --------------------------------------------------------------------------
  logic [AXI_DATA_W-1:0] r_mem [c_mem_depth];

  // --------------------------------------------------------------------------
  // Write engine
  // --------------------------------------------------------------------------
  wr_state_t             r_wr_state, w_wr_state_nxt;
  logic [AXI_ID_W-1:0]   r_wr_id;
  logic [MEM_ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [AXI_LEN_W-1:0]  r_wr_len, r_wr_cnt;
  logic [1:0]            r_wr_burst;
  logic                  r_wr_oor, r_wr_err;
  logic                  w_aw_hs, w_w_hs, w_wr_last_beat;

  assign w_aw_hs        = axi_awvalid_i & axi_awready_o;
  assign w_w_hs         = axi_wvalid_i & axi_wready_o;
  assign w_wr_last_beat = (r_wr_cnt == r_wr_len);
  // every non-FIXED burst type walks forward one word and wraps at the top
  assign w_wr_addr_nxt  = (r_wr_burst == c_burst_fixed) ? r_wr_addr : r_wr_addr + c_addr_one;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_wr_state <= W_IDLE;
    else           r_wr_state <= w_wr_state_nxt;
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    axi_awready_o  = 1'b0;
    axi_wready_o   = 1'b0;
    axi_bvalid_o   = 1'b0;
    axi_bresp_o    = c_resp_okay;
    case (r_wr_state)
      W_IDLE: begin
        axi_awready_o = 1'b1;
        if (w_aw_hs) w_wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        axi_wready_o = 1'b1;
        // the beat count, not wlast, ends the burst
        if (w_w_hs && w_wr_last_beat) w_wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        axi_bvalid_o = 1'b1;
        if (r_wr_oor)      axi_bresp_o = c_resp_decerr;
        else if (r_wr_err) axi_bresp_o = c_resp_slverr;
        if (axi_bready_i) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wr_id    <= '0;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_wr_cnt   <= '0;
      r_wr_burst <= '0;
      r_wr_oor   <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_wr_id    <= axi_awid_i;
        r_wr_addr  <= axi_awaddr_i[MEM_ADDR_W+1:2];
        r_wr_len   <= axi_awlen_i;
        r_wr_burst <= axi_awburst_i;
        r_wr_oor   <= |axi_awaddr_i[AXI_ADDR_W-1:MEM_ADDR_W+2];
        r_wr_cnt   <= '0;
        r_wr_err   <= 1'b0;
      end
      if (w_w_hs) begin
        // a wlast that disagrees with the beat count is reported, not obeyed
        if (axi_wlast_i != w_wr_last_beat) r_wr_err <= 1'b1;
        r_wr_cnt  <= r_wr_cnt + c_cnt_one;
        r_wr_addr <= w_wr_addr_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_w_hs && !r_wr_oor) begin
      for (int b = 0; b < c_lanes; b++) begin
        if (axi_wstrb_i[b]) r_mem[r_wr_addr][8*b +: 8] <= axi_wdata_i[8*b +: 8];
      end
    end
  end

  assign axi_bid_o = r_wr_id;

  // --------------------------------------------------------------------------
  // Read engine
  // --------------------------------------------------------------------------
  rd_state_t             r_rd_state, w_rd_state_nxt;
  logic [AXI_ID_W-1:0]   r_rd_id;
  logic [MEM_ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [AXI_LEN_W-1:0]  r_rd_len, r_rd_cnt;
  logic [1:0]            r_rd_burst;
  logic                  r_rd_oor;
  logic [AXI_DATA_W-1:0] r_rdata;
  logic                  w_ar_hs, w_r_hs, w_rd_last_beat;

  assign w_ar_hs        = axi_arvalid_i & axi_arready_o;
  assign w_r_hs         = axi_rvalid_o & axi_rready_i;
  assign w_rd_last_beat = (r_rd_cnt == r_rd_len);
  assign w_rd_addr_nxt  = (r_rd_burst == c_burst_fixed) ? r_rd_addr : r_rd_addr + c_addr_one;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_rd_state <= R_IDLE;
    else           r_rd_state <= w_rd_state_nxt;
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    axi_arready_o  = 1'b0;
    axi_rvalid_o   = 1'b0;
    axi_rlast_o    = 1'b0;
    axi_rresp_o    = c_resp_okay;
    case (r_rd_state)
      R_IDLE: begin
        axi_arready_o = 1'b1;
        if (w_ar_hs) w_rd_state_nxt = R_LOAD;
      end
      R_LOAD: w_rd_state_nxt = R_DATA;
      R_DATA: begin
        axi_rvalid_o = 1'b1;
        axi_rlast_o  = w_rd_last_beat;
        if (r_rd_oor) axi_rresp_o = c_resp_decerr;
        if (axi_rready_i && w_rd_last_beat) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // rdata is a registered copy of the current word; it only moves on LOAD or
  // on an accepted non-final beat, so it holds while the master stalls. A
  // same-cycle write to that word lands after the read and is not seen.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_rd_id    <= '0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_rd_cnt   <= '0;
      r_rd_burst <= '0;
      r_rd_oor   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rd_id    <= axi_arid_i;
        r_rd_addr  <= axi_araddr_i[MEM_ADDR_W+1:2];
        r_rd_len   <= axi_arlen_i;
        r_rd_burst <= axi_arburst_i;
        r_rd_oor   <= |axi_araddr_i[AXI_ADDR_W-1:MEM_ADDR_W+2];
        r_rd_cnt   <= '0;
      end
      if (r_rd_state == R_LOAD) begin
        r_rdata <= r_rd_oor ? '0 : r_mem[r_rd_addr];
      end
      if (w_r_hs && !w_rd_last_beat) begin
        r_rd_addr <= w_rd_addr_nxt;
        r_rd_cnt  <= r_rd_cnt + c_cnt_one;
        r_rdata   <= r_rd_oor ? '0 : r_mem[w_rd_addr_nxt];
      end
    end
  end

  assign axi_rid_o   = r_rd_id;
  assign axi_rdata_o = r_rdata;

  // side-band attributes and the sub-word address bits carry no meaning here
  logic w_unused_sideband;
  assign w_unused_sideband = ^{axi_awsize_i, axi_awlock_i, axi_awcache_i, axi_awprot_i,
                               axi_awqos_i, axi_awaddr_i[1:0],
                               axi_arsize_i, axi_arlock_i, axi_arcache_i, axi_arprot_i,
                               axi_arqos_i, axi_araddr_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_iob_eth_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob_eth_axi_mem_responder
//  Purpose  : Self-checking bench for iob_eth_axi_mem_responder. Directed
//             sequences, a table of byte-strobe vectors and randomized bursts,
//             all checked against a word-array reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iob_eth_axi_mem_responder;
  localparam int AW = 24, LW = 8, IW = 1, MW = 12;
  localparam int DEPTH = 2 ** MW;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [LW-1:0] awlen, arlen;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, arvalid, arready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic          wlast, wvalid, wready, bvalid, bready;
  logic          rlast, rvalid, rready;

  iob_eth_axi_mem_responder dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awburst_i(awburst),
    .axi_awsize_i(3'd2), .axi_awlock_i(1'b0), .axi_awcache_i(4'd0), .axi_awprot_i(3'd0),
    .axi_awqos_i(4'd0), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
    .axi_wready_o(wready),
    .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arburst_i(arburst),
    .axi_arsize_i(3'd2), .axi_arlock_i(1'b0), .axi_arcache_i(4'd0), .axi_arprot_i(3'd0),
    .axi_arqos_i(4'd0), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: plain word array plus a "contents defined" flag
  logic [31:0] mdl   [DEPTH];
  bit          known [DEPTH];
  logic [31:0] wbuf  [256];
  logic [3:0]  sbuf  [256];
  logic [31:0] rbuf  [256];

  function automatic bit is_oor(input logic [AW-1:0] a);
    return |a[AW-1:MW+2];
  endfunction

  function automatic void mdl_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst);
    int w;
    w = int'(addr[MW+1:2]);
    if (is_oor(addr)) return;
    for (int b = 0; b <= len; b++) begin
      for (int k = 0; k < 4; k++)
        if (sbuf[b][k]) mdl[w][8*k +: 8] = wbuf[b][8*k +: 8];
      if (sbuf[b] == 4'hF) known[w] = 1'b1;
      if (burst != 2'b00) w = (w + 1) % DEPTH;
    end
  endfunction

  // All tasks start and end at a falling edge.
  task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                          input int bad_beat, input int bstall);
    logic [IW-1:0] id;
    logic [1:0]    exp_resp;
    int t;
    id = IW'($urandom_range(0, 1));
    awid = id; awaddr = addr; awlen = LW'(len); awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 20) begin @(negedge clk); t++; end
    check("awready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b];
      wlast = (b == len) ^ (b == bad_beat);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 20) begin @(negedge clk); t++; end
      check("wready", wready, 1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    check("bvalid", bvalid, 1);
    repeat (bstall) @(negedge clk);
    check("bvalid_hold", bvalid, 1);
    exp_resp = is_oor(addr) ? 2'b11 : ((bad_beat >= 0 && bad_beat <= len) ? 2'b10 : 2'b00);
    check("bresp", bresp, exp_resp);
    check("bid", bid, id);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("awready_after_b", awready, 1);
    check("bvalid_after_b", bvalid, 0);
    mdl_write(addr, len, burst);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                         input int stall_beat, input int stall_cycles, input bit rnd_stall);
    logic [IW-1:0] id;
    logic [31:0]   d0;
    logic          l0;
    int t, s, w;
    bit oor;
    id = IW'($urandom_range(0, 1));
    oor = is_oor(addr);
    w = int'(addr[MW+1:2]);
    arid = id; araddr = addr; arlen = LW'(len); arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 20) begin @(negedge clk); t++; end
    check("arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_load", rvalid, 0);
    @(negedge clk);
    check("rvalid_latency", rvalid, 1);
    for (int b = 0; b <= len; b++) begin
      s = (b == stall_beat) ? stall_cycles : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      check("rvalid", rvalid, 1);
      d0 = rdata; l0 = rlast;
      repeat (s) begin
        @(negedge clk);
        check("rdata_hold", rdata, d0);
        check("rlast_hold", rlast, l0);
      end
      if (oor) check("rdata_oor", rdata, 32'h0);
      else if (known[w]) check("rdata", rdata, mdl[w]);
      check("rlast", rlast, (b == len));
      check("rresp", rresp, oor ? 2'b11 : 2'b00);
      check("rid", rid, id);
      rbuf[b] = rdata;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      if (burst != 2'b00) w = (w + 1) % DEPTH;
    end
    check("rvalid_end", rvalid, 0);
    check("arready_end", arready, 1);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   init;
    logic [3:0]    strb;
    logic [31:0]   wd;
    logic [31:0]   exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len, start;
    logic [1:0] burst;

    vecs[0] = '{24'h200, 32'h11223344, 4'b0101, 32'hFFFFFFFF, 32'h11FF33FF};
    vecs[1] = '{24'h204, 32'h11223344, 4'b1010, 32'hFFFFFFFF, 32'hFF22FF44};
    vecs[2] = '{24'h208, 32'hAABBCCDD, 4'b0000, 32'h12345678, 32'hAABBCCDD};
    vecs[3] = '{24'h20C, 32'hAABBCCDD, 4'b1111, 32'h12345678, 32'h12345678};
    vecs[4] = '{24'h210, 32'h00000000, 4'b0001, 32'h000000EE, 32'h000000EE};
    vecs[5] = '{24'h214, 32'hCAFEF00D, 4'b1000, 32'h5A000000, 32'h5AFEF00D};

    awid = '0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bid", bid, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    arst_n = 1'b1;
    @(negedge clk);

    // basic 4-beat INCR write and readback
    for (int b = 0; b < 4; b++) begin wbuf[b] = 32'hA0 + b; sbuf[b] = 4'hF; end
    do_write(24'h100, 3, 2'b01, -1, 0);
    do_read(24'h100, 3, 2'b01, -1, 0, 0);
    for (int b = 0; b < 4; b++) check("incr_data", rbuf[b], 32'hA0 + b);

    // stall on beat 2
    do_read(24'h100, 3, 2'b01, 2, 5, 0);
    for (int b = 0; b < 4; b++) check("stall_data", rbuf[b], 32'hA0 + b);

    // byte strobe vectors
    for (int i = 0; i < 6; i++) begin
      wbuf[0] = vecs[i].init; sbuf[0] = 4'hF;
      do_write(vecs[i].addr, 0, 2'b01, -1, 0);
      wbuf[0] = vecs[i].wd; sbuf[0] = vecs[i].strb;
      do_write(vecs[i].addr, 0, 2'b01, -1, 1);
      do_read(vecs[i].addr, 0, 2'b01, -1, 0, 0);
      check("strobe_vec", rbuf[0], vecs[i].exp);
    end

    // fill words 0..63 with known data
    for (int b = 0; b < 64; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'hF; end
    do_write(24'h0, 63, 2'b01, -1, 0);

    // out-of-range write aliases word 0 in the low bits but must not touch it
    for (int b = 0; b < 2; b++) begin wbuf[b] = 32'hDEAD0000 + b; sbuf[b] = 4'hF; end
    do_write(24'h1 << (MW + 2), 1, 2'b01, -1, 0);
    do_read(24'h0, 1, 2'b01, -1, 0, 0);
    check("oor_untouched", rbuf[0], mdl[0]);
    do_read(24'h1 << (MW + 2), 1, 2'b01, -1, 0, 0);

    // early wlast: all 4 beats still accepted, SLVERR
    for (int b = 0; b < 4; b++) begin wbuf[b] = 32'hB0 + b; sbuf[b] = 4'hF; end
    do_write(24'h300, 3, 2'b01, 1, 0);
    do_read(24'h300, 3, 2'b01, -1, 0, 0);
    check("early_wlast_beat3", rbuf[3], 32'hB3);

    // address wraps at the top of memory
    for (int b = 0; b < 4; b++) begin wbuf[b] = 32'hC0 + b; sbuf[b] = 4'hF; end
    do_write(24'h3FF8, 3, 2'b01, -1, 0);
    do_read(24'h3FF8, 3, 2'b10, -1, 0, 0);
    check("wrap_word0", rbuf[2], 32'hC2);

    // FIXED burst merges all beats onto one word
    wbuf[0] = 32'h11111111; sbuf[0] = 4'hF;
    wbuf[1] = 32'h22222222; sbuf[1] = 4'b0010;
    wbuf[2] = 32'h33333333; sbuf[2] = 4'b1000;
    do_write(24'h400, 2, 2'b00, -1, 0);
    do_read(24'h400, 2, 2'b00, -1, 0, 0);
    check("fixed_merge", rbuf[2], 32'h33112211);

    // randomized traffic in the known region
    for (int i = 0; i < 40; i++) begin
      len   = int'($urandom_range(0, 7));
      burst = 2'($urandom_range(0, 3));
      start = int'($urandom_range(0, 63 - len));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= len; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'($urandom); end
        do_write(AW'(start * 4), len, burst, -1, int'($urandom_range(0, 2)));
      end else begin
        do_read(AW'(start * 4), len, burst, -1, 0, 1);
      end
    end

    // reset in the middle of a write burst; accepted beats stay in memory
    awid = '0; awaddr = 24'h180; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    wdata = 32'h55550000;
    @(negedge clk);
    wdata = 32'h55550001;
    @(negedge clk);
    wvalid = 1'b0;
    arst_n = 1'b0;
    #1;
    check("midrst_awready", awready, 1);
    check("midrst_wready", wready, 0);
    check("midrst_bvalid", bvalid, 0);
    @(negedge clk);
    arst_n = 1'b1;
    mdl[96] = 32'h55550000; known[96] = 1'b1;
    mdl[97] = 32'h55550001; known[97] = 1'b1;
    @(negedge clk);
    do_read(24'h180, 1, 2'b01, -1, 0, 0);
    check("midrst_partial", rbuf[1], 32'h55550001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
